ex_stage: RTL
=============

# ex_stage

Execute stage of the five-stage MIPS pipeline. It consumes the decoded controls and operands leaving the ID/EX latch and computes the ALU result, zero flag, branch target and destination register. It registers all results, plus the forwarded WB/M controls, into the EX/MEM boundary. When compiled in, an iterative multiplier occupies the stage for multiple cycles and raises `stall` to freeze upstream stages.

## Interface
- No parameters; widths are fixed by the 32-bit datapath.
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `rst` in 1: reset; one clock; reset is synchronous and active-high.
- `wb_ctl` in 2: WB controls; passed through unchanged.
- `m_ctl` in 3: MEM controls; passed through unchanged.
- `regdst` in 1: 1 selects `instr_1511` as destination, 0 selects `instr_2016`.
- `alusrc` in 1: 1 selects `s_extend` as ALU operand B, 0 selects `rdata2`.
- `aluop` in 2: ALU operation class.
- `npc` in 32: PC+4 of the instruction.
- `rdata1`, `rdata2` in 32 each: register file operands.
- `s_extend` in 32: sign-extended immediate; bits [5:0] are the funct field.
- `instr_2016`, `instr_1511` in 5 each: rt and rd fields.
- `wb_ctlout` out 2, `m_ctlout` out 3: registered controls.
- `add_result` out 32: registered branch target.
- `zero` out 1: registered; 1 when the ALU result equals 0.
- `alu_result` out 32: registered ALU or multiplier result.
- `rdata2out` out 32: registered store data (`rdata2`).
- `muxout` out 5: registered destination register.
- `stall` out 1: combinational; while high, ID/EX and earlier stages hold.

## Operation
- Operand B is `alusrc ? s_extend : rdata2`.
- Destination is `regdst ? instr_1511 : instr_2016`.
- Branch target is `npc + (s_extend << 2)`, modulo 2^32.
- `aluop` decode:
  - 00: add
  - 01: sub
  - 11: add
  - 10: decode by funct
- Funct decode under `aluop`=10:
  - 0x20: add
  - 0x22: sub
  - 0x24: and
  - 0x25: or
  - 0x2A: slt (signed compare; result is 1 or 0)
  - any other funct: result 0
- Add and sub wrap modulo 2^32; no overflow trap.
- `zero` is computed from the final registered result, including multiplier results.
- FSM states (multiplier builds only): IDLE, BUSY, DONE.
  - IDLE → BUSY when `aluop`=10 and funct=0x18 (MULT). Load operands `rdata1` and `rdata2`, clear the product, set count to 0.
  - BUSY: one shift-add step per cycle. Go to DONE after 32 steps.
  - DONE → IDLE unconditionally.
- The multiplier result is the low 32 bits of the unsigned product.
- EX/MEM register load rules:
  - IDLE with a non-MULT instruction: normal capture every cycle.
  - IDLE with MULT, and every BUSY cycle: capture a bubble (`wb_ctlout`=0, `m_ctlout`=0; data fields don't-care, driven 0).
  - DONE: capture the product with the held instruction's controls and destination.
- `stall` = (IDLE and MULT presented) or BUSY. It is low in DONE, so ID/EX advances on the same edge the product is captured.

## Timing
- Non-MULT latency: 1 cycle, inputs to registered outputs.
- MULT presented in cycle 0:
  - `stall` is high for cycles 0–32 (33 cycles).
  - DONE occurs in cycle 33.
  - The product is visible on `alu_result` after the edge ending cycle 33.
- Reset values: all registered outputs 0, FSM in IDLE, `stall` 0 while `rst` is high.
- Reset mid-multiply: the FSM returns to IDLE, the partial product is discarded, and outputs clear on that edge.
- Back-to-back MULTs: DONE → IDLE, then the next MULT starts a fresh 33-cycle stall. There is no overlap.
- Upstream must hold all inputs stable while `stall` is high.

## Configuration
- `EX_MULT_EN` defined:
  - The FSM and `ex_mult` are instantiated.
  - Funct 0x18 behaves as described in Operation.
- `EX_MULT_EN` undefined:
  - There is no FSM and `stall` is tied to 0.
  - Funct 0x18 is an unknown funct: single-cycle, `alu_result` 0, `zero` 1.

## Structure
- Package `ex_pkg` holds:
  - `aluop` encodings
  - funct constants (ADD, SUB, AND, OR, SLT, MULT)
  - the internal 3-bit ALU-control enum
  - the FSM state enum
- Sub-module `ex_mult` holds the iterative 32×32 shift-add multiplier.
  - Ports: start, a, b, busy, done, product[31:0].
  - The FSM and the EX/MEM capture logic stay in `ex_stage`.

## Test plan
- Reset: assert `rst` for 2 cycles with random inputs → all outputs 0 and `stall` 0.
- R-type add: `aluop`=10, funct 0x20, `rdata1`=5, `rdata2`=7, `regdst`=1, `instr_1511`=9 → next edge: `alu_result`=12, `zero`=0, `muxout`=9, controls passed through.
- Branch: `aluop`=01, `rdata1`=`rdata2`=0x1234, `npc`=0x100, `s_extend`=0xFFFFFFFE → `zero`=1 and `add_result`=0xF8.
- slt signed: `rdata1`=0xFFFFFFFF, `rdata2`=1 → `alu_result`=1. Swap the operands → 0.
- MULT (with `EX_MULT_EN`): `rdata1`=0x10001, `rdata2`=3 →
  - `stall` high for exactly 33 cycles, with bubbles (`wb_ctlout`=0) during that time;
  - then `alu_result`=0x30003 with the held controls.
- Reset mid-MULT: assert `rst` at BUSY step 10 → outputs 0 and `stall` 0 on the next edge. A subsequent add completes in 1 cycle.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the execute stage (aluop classes, funct codes,
// internal ALU control, multiplier FSM states) and the ALU-control decoder.
package ex_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ADDX  = 2'b11;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_MULT = 6'h18;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_ZERO, ALU_MULT
    } alu_ctl_e;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} ex_state_e;

    // MULT is always decoded here; builds without the multiplier treat it
    // like any unknown funct (result 0) in the ALU.
    function automatic alu_ctl_e alu_decode(input logic [1:0] aluop,
                                            input logic [5:0] funct);
        alu_ctl_e c;
        c = ALU_ADD;
        case (aluop)
            ALUOP_ADD, ALUOP_ADDX: c = ALU_ADD;
            ALUOP_SUB:             c = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD:  c = ALU_ADD;
                    FUNCT_SUB:  c = ALU_SUB;
                    FUNCT_AND:  c = ALU_AND;
                    FUNCT_OR:   c = ALU_OR;
                    FUNCT_SLT:  c = ALU_SLT;
                    FUNCT_MULT: c = ALU_MULT;
                    default:    c = ALU_ZERO;
                endcase
            end
            default: c = ALU_ADD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ex_if.sv
// ex_if: ID/EX operands and controls in, EX/MEM results out, plus stall.
// master = upstream/downstream pipeline side, slave = ex_stage.
interface ex_if;
    logic [1:0]  wb_ctl;
    logic [2:0]  m_ctl;
    logic        regdst;
    logic        alusrc;
    logic [1:0]  aluop;
    logic [31:0] npc;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] s_extend;
    logic [4:0]  instr_2016;
    logic [4:0]  instr_1511;

    logic [1:0]  wb_ctlout;
    logic [2:0]  m_ctlout;
    logic [31:0] add_result;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] rdata2out;
    logic [4:0]  muxout;
    logic        stall;

    modport master (
        output wb_ctl, m_ctl, regdst, alusrc, aluop, npc, rdata1, rdata2,
               s_extend, instr_2016, instr_1511,
        input  wb_ctlout, m_ctlout, add_result, zero, alu_result, rdata2out,
               muxout, stall
    );

    modport slave (
        input  wb_ctl, m_ctl, regdst, alusrc, aluop, npc, rdata1, rdata2,
               s_extend, instr_2016, instr_1511,
        output wb_ctlout, m_ctlout, add_result, zero, alu_result, rdata2out,
               muxout, stall
    );
endinterface

// File: rtl/ex_mult.sv
// ex_mult: iterative 32x32 shift-add multiplier, one step per cycle,
// keeping the low 32 bits of the unsigned product.
module ex_mult (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [4:0]  cnt;

    // done marks the cycle whose closing edge performs the 32nd step, so the
    // product is complete in the following cycle.
    assign done = busy && (cnt == 5'd31);

    // load on start, then shift-add until 32 steps are done
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            cnt     <= '0;
            mcand   <= a;
            mplier  <= b;
            product <= '0;
        end else if (busy) begin
            if (mplier[0]) product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
            if (done) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage. ALU, branch target and destination select,
// registered into the EX/MEM boundary. Define EX_MULT_EN to build in the
// iterative multiplier (funct 0x18) and its stall FSM.
module ex_stage
    import ex_pkg::*;
(
    input  logic clk,
    input  logic rst,
    ex_if.slave  bus
);
    logic [31:0] opb;
    logic [31:0] alu_out;
    logic [31:0] res;
    logic [31:0] br_tgt;
    logic [4:0]  dest;
    logic        bubble;
    alu_ctl_e    ctl;

    assign opb    = bus.alusrc ? bus.s_extend : bus.rdata2;
    assign dest   = bus.regdst ? bus.instr_1511 : bus.instr_2016;
    assign br_tgt = bus.npc + (bus.s_extend << 2);
    assign ctl    = alu_decode(bus.aluop, bus.s_extend[5:0]);

    // single-cycle ALU; unknown functs (and MULT here) produce 0
    always_comb begin
        alu_out = '0;
        case (ctl)
            ALU_ADD: alu_out = bus.rdata1 + opb;
            ALU_SUB: alu_out = bus.rdata1 - opb;
            ALU_AND: alu_out = bus.rdata1 & opb;
            ALU_OR:  alu_out = bus.rdata1 | opb;
            ALU_SLT: alu_out = {31'b0, $signed(bus.rdata1) < $signed(opb)};
            default: alu_out = '0;
        endcase
    end

`ifdef EX_MULT_EN
    ex_state_e   state, state_nxt;
    logic        stall_c;
    logic        mul_start;
    logic        mul_busy;
    logic        mul_done;
    logic [31:0] mul_prod;

    ex_mult u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.rdata1),
        .b       (bus.rdata2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // next state, stall, bubble insertion and result select
    always_comb begin
        state_nxt = state;
        mul_start = 1'b0;
        stall_c   = 1'b0;
        bubble    = 1'b0;
        res       = alu_out;
        case (state)
            S_IDLE: begin
                if (ctl == ALU_MULT) begin
                    mul_start = 1'b1;
                    stall_c   = 1'b1;
                    bubble    = 1'b1;
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                stall_c = 1'b1;
                bubble  = 1'b1;
                if (mul_done)      state_nxt = S_DONE;
                else if (!mul_busy) state_nxt = S_IDLE;
            end
            S_DONE: begin
                // inputs still hold the MULT; capture its controls with the product
                res       = mul_prod;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.stall = stall_c & ~rst;
`else
    assign bubble    = 1'b0;
    assign res       = alu_out;
    assign bus.stall = 1'b0;
`endif

    // EX/MEM boundary: reset and bubbles clear everything, else capture
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            bus.wb_ctlout  <= '0;
            bus.m_ctlout   <= '0;
            bus.add_result <= '0;
            bus.zero       <= 1'b0;
            bus.alu_result <= '0;
            bus.rdata2out  <= '0;
            bus.muxout     <= '0;
        end else begin
            bus.wb_ctlout  <= bus.wb_ctl;
            bus.m_ctlout   <= bus.m_ctl;
            bus.add_result <= br_tgt;
            bus.zero       <= (res == 32'd0);
            bus.alu_result <= res;
            bus.rdata2out  <= bus.rdata2;
            bus.muxout     <= dest;
        end
    end
endmodule
